clock_gen_multi: RTL and testbench
==================================

CLOCK_GEN_MULTI -- requirements
Module: clock_gen_multi

Interface
REQ-001 Parameter WIDTH, default 16, divider/counter width in bits (>= 2).
REQ-002 Parameter NUM_CH, default 2, number of independent divider channels (>= 1).
REQ-003 CLOCK_50  input  1  system clock; all state on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  NUM_CH  per-channel enable.
REQ-006 mode  input  NUM_CH  per-channel mode: 0 = TOGGLE (50% clock), 1 = PULSE (one-cycle strobe).
REQ-007 divider  input  NUM_CH x WIDTH  per-channel requested divider value D.
REQ-008 load  input  NUM_CH  per-channel one-cycle request to capture divider[ch] into its shadow register.
REQ-009 sync  input  1  restart all channels phase-aligned.
REQ-010 clk_out  output  NUM_CH  divided clock (TOGGLE) or strobe (PULSE), registered.
REQ-011 tick  output  NUM_CH  one-cycle pulse at every terminal count, registered.
REQ-012 pending  output  NUM_CH  high while a loaded divider awaits application.

Function
REQ-013 Each channel SHALL hold an active divider D_act, a shadow divider D_sh, and a WIDTH-bit counter cnt.
REQ-014 With en[ch] high and cnt != D_act, cnt SHALL increment by 1 per cycle.
REQ-015 With en[ch] high and cnt == D_act (terminal), cnt SHALL return to 0 on the next edge, and tick[ch] SHALL be 1 for exactly that following cycle.
REQ-016 Period SHALL be D_act+1 cycles between ticks; D_act = 0 gives tick high every cycle.
REQ-017 TOGGLE mode: clk_out[ch] SHALL invert on each edge following a terminal cycle; output period 2*(D_act+1) cycles, 50% duty.
REQ-018 PULSE mode: clk_out[ch] SHALL equal tick[ch].
REQ-019 A mode change SHALL take effect at the next terminal count; clk_out SHALL be forced to 0 at that boundary when switching to PULSE.
REQ-020 load[ch] high SHALL capture divider[ch] into D_sh and set pending[ch] on the next edge; a load while pending SHALL overwrite D_sh.
REQ-021 When enabled, D_sh SHALL transfer to D_act on the edge following a terminal cycle, clearing pending; no partial period with a mixed divider is permitted.
REQ-022 With en[ch] low: cnt, clk_out[ch], and tick[ch] SHALL be 0 next edge; a pending D_sh SHALL transfer to D_act immediately and pending SHALL clear.
REQ-023 Load and terminal in the same cycle: the newly loaded value SHALL be applied at that boundary, with pending clearing next edge.
REQ-024 On the first edge after en rises, cnt SHALL be 0; the first tick SHALL occur D_act+1 cycles later.
REQ-025 sync high SHALL, on the next edge, clear cnt, clk_out, and tick of every channel and apply any pending D_sh; sync overrides terminal, load-apply, and mode timing in that cycle.
REQ-026 sync and load[ch] in the same cycle: divider[ch] SHALL become D_act directly and pending[ch] SHALL stay 0.
REQ-027 Channels SHALL be fully independent except for sync.
REQ-028 All comparisons SHALL be unsigned WIDTH-bit; cnt never exceeds D_act; D_act = 2^WIDTH-1 SHALL be legal.

Reset
REQ-029 reset SHALL asynchronously force cnt = 0, clk_out = 0, tick = 0, pending = 0, and mode register = TOGGLE for every channel.
REQ-030 reset SHALL set D_act = D_sh = 1 (period 2) so an enable before any load yields a defined clock.
REQ-031 reset asserted mid-period SHALL discard any partial period and pending load; operation resumes per REQ-024 after release.

Structure
REQ-032 Shared package clock_gen_pkg SHALL hold the mode enum (MODE_TOGGLE = 0, MODE_PULSE = 1), the default WIDTH/NUM_CH constants, and the reset divider constant (1).
REQ-033 One sub-module, clock_gen_channel, SHALL implement a single channel; clock_gen_multi SHALL instantiate NUM_CH copies via generate and fan out sync.

Verification
REQ-034 Reset, then en[0] = 1, mode TOGGLE, no load -> clk_out[0] period 4 cycles, tick[0] every 2 cycles, first tick 2 cycles after en.
REQ-035 load D = 3 mid-period in TOGGLE -> pending = 1 until the current period ends, then clk_out period 8 (4 high, 4 low), no short/long half-period.
REQ-036 mode PULSE with D = 4 -> clk_out = tick, high 1 cycle in every 5; D = 0 -> clk_out constant 1 while enabled.
REQ-037 ch0 D = 2 and ch1 D = 5 running, assert sync 1 cycle -> both cnt = 0 and clk_out = 0 next edge; first ticks at +3 and +6 cycles.
REQ-038 load D = 7 with en low -> pending clears next edge; en high -> first tick after 8 cycles; reset pulse mid-period -> all outputs 0 immediately (asynchronously).
REQ-039 WIDTH = 4, load D = 15 -> tick every 16 cycles, cnt wraps 15 -> 0 with no overflow.

Source files
------------

// File: rtl/clock_gen_multi_pkg.sv
// Shared types and constants for the multi-channel clock divider.
// Mode encoding, default sizing and the divider value applied at reset.
// Imported by the interface, the channel and the top.
package clock_gen_pkg;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_NUM_CH = 2;
  // Period of 2 cycles so an enable before any load still yields a clock.
  localparam int RST_DIV    = 1;

  typedef enum logic {
    MODE_TOGGLE = 1'b0,
    MODE_PULSE  = 1'b1
  } mode_e;

endpackage

// File: rtl/clock_gen_multi_if.sv
// Control/status bundle for clock_gen_multi: per-channel enable, mode,
// divider and load requests, global sync, and the per-channel outputs.
// master drives the controls; slave is the divider block.
interface clock_gen_multi_if
  import clock_gen_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH
) ();

  logic [NUM_CH-1:0]            en;
  logic [NUM_CH-1:0]            mode;
  logic [NUM_CH-1:0][WIDTH-1:0] divider;
  logic [NUM_CH-1:0]            load;
  logic                         sync;
  logic [NUM_CH-1:0]            clk_out;
  logic [NUM_CH-1:0]            tick;
  logic [NUM_CH-1:0]            pending;

  modport master (
    output en, mode, divider, load, sync,
    input  clk_out, tick, pending
  );

  modport slave (
    input  en, mode, divider, load, sync,
    output clk_out, tick, pending
  );

endinterface

// File: rtl/clock_gen_multi_channel.sv
// One divider channel: counter 0..D_act, tick on the cycle after terminal,
// clk_out as 50% toggle or as a copy of tick. Outputs registered, 1 cycle
// after the terminal cycle. No backpressure; loads are shadowed until a boundary.
module clock_gen_channel
  import clock_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             en,
  input  logic             mode,
  input  logic             load,
  input  logic             sync,
  input  logic [WIDTH-1:0] divider,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] RST_D   = WIDTH'(RST_DIV);

  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] d_act, d_act_nxt;
  logic [WIDTH-1:0] d_sh, d_sh_nxt;
  logic             pending_nxt, clk_out_nxt, tick_nxt;
  mode_e            mode_r, mode_nxt;
  logic             terminal;

  assign terminal = en && (cnt == d_act);

  // Next-state: sync beats disable beats terminal beats normal counting.
  always_comb begin
    cnt_nxt     = cnt;
    d_act_nxt   = d_act;
    d_sh_nxt    = d_sh;
    pending_nxt = pending;
    clk_out_nxt = clk_out;
    tick_nxt    = 1'b0;
    mode_nxt    = mode_r;
    if (sync) begin
      // Phase restart; a load in the same cycle goes straight to D_act.
      cnt_nxt     = '0;
      clk_out_nxt = 1'b0;
      mode_nxt    = mode_e'(mode);
      pending_nxt = 1'b0;
      d_act_nxt   = load ? divider : d_sh;
      d_sh_nxt    = load ? divider : d_sh;
    end else if (!en) begin
      // Idle: outputs cleared, any shadow value is applied right away.
      cnt_nxt     = '0;
      clk_out_nxt = 1'b0;
      mode_nxt    = mode_e'(mode);
      d_act_nxt   = d_sh;
      if (load) begin
        d_sh_nxt    = divider;
        pending_nxt = 1'b1;
      end else begin
        pending_nxt = 1'b0;
      end
    end else if (terminal) begin
      // Period boundary: new divider and new mode both take effect here.
      cnt_nxt     = '0;
      tick_nxt    = 1'b1;
      mode_nxt    = mode_e'(mode);
      pending_nxt = 1'b0;
      d_act_nxt   = load ? divider : d_sh;
      d_sh_nxt    = load ? divider : d_sh;
      if (mode_nxt == MODE_PULSE) begin
        // Entering PULSE from TOGGLE starts low; staying in PULSE follows tick.
        clk_out_nxt = (mode_r == MODE_PULSE);
      end else begin
        clk_out_nxt = ~clk_out;
      end
    end else begin
      cnt_nxt = cnt + CNT_ONE;
      if (mode_r == MODE_PULSE) begin
        clk_out_nxt = 1'b0;
      end
      if (load) begin
        d_sh_nxt    = divider;
        pending_nxt = 1'b1;
      end
    end
  end

  // State registers with asynchronous reset to a period-2 TOGGLE channel.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      d_act   <= RST_D;
      d_sh    <= RST_D;
      pending <= 1'b0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      mode_r  <= MODE_TOGGLE;
    end else begin
      cnt     <= cnt_nxt;
      d_act   <= d_act_nxt;
      d_sh    <= d_sh_nxt;
      pending <= pending_nxt;
      clk_out <= clk_out_nxt;
      tick    <= tick_nxt;
      mode_r  <= mode_nxt;
    end
  end

endmodule

// File: rtl/clock_gen_multi.sv
// NUM_CH independent clock dividers sharing only the sync restart.
// Latency: outputs registered inside each channel, 1 cycle after terminal.
// No backpressure; controls are sampled every rising edge of CLOCK_50.
module clock_gen_multi
  import clock_gen_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int NUM_CH = DEF_NUM_CH
) (
  input  logic               CLOCK_50,
  input  logic               reset,
  clock_gen_multi_if.slave   bus
);

  logic [NUM_CH-1:0] clk_out_w;
  logic [NUM_CH-1:0] tick_w;
  logic [NUM_CH-1:0] pending_w;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clock_gen_channel #(
      .WIDTH (WIDTH)
    ) u_ch (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .en       (bus.en[g]),
      .mode     (bus.mode[g]),
      .load     (bus.load[g]),
      .sync     (bus.sync),
      .divider  (bus.divider[g]),
      .clk_out  (clk_out_w[g]),
      .tick     (tick_w[g]),
      .pending  (pending_w[g])
    );
  end

  assign bus.clk_out = clk_out_w;
  assign bus.tick    = tick_w;
  assign bus.pending = pending_w;

endmodule

// File: tb/tb_clock_gen_multi.sv
// Directed bench for clock_gen_multi: a 2-channel 16-bit instance and a
// 1-channel 4-bit instance, with output waveforms captured into bit vectors
// and compared against hand-derived patterns.
module tb_clock_gen_multi;

  logic CLOCK_50;
  logic reset;
  int   checks;
  int   failures;

  clock_gen_multi_if #(.WIDTH(16), .NUM_CH(2)) bus0 ();
  clock_gen_multi_if #(.WIDTH(4),  .NUM_CH(1)) bus1 ();

  clock_gen_multi #(.WIDTH(16), .NUM_CH(2)) dut0 (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus0)
  );

  clock_gen_multi #(.WIDTH(4), .NUM_CH(1)) dut1 (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .bus      (bus1)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  logic [31:0] tk, ck, pd, tk1;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    bus0.en = '0; bus0.mode = '0; bus0.divider = '0; bus0.load = '0; bus0.sync = 1'b0;
    bus1.en = '0; bus1.mode = '0; bus1.divider = '0; bus1.load = '0; bus1.sync = 1'b0;

    // Reset state
    step();
    step();
    chk("rst_clk_out", 32'(bus0.clk_out), 32'h0);
    chk("rst_tick",    32'(bus0.tick),    32'h0);
    chk("rst_pending", 32'(bus0.pending), 32'h0);
    chk("rst_w4_tick", 32'(bus1.tick),    32'h0);
    reset = 1'b0;
    step();

    // Default divider 1 after reset, TOGGLE: tick every 2, clk_out period 4
    bus0.en[0] = 1'b1;
    tk = '0; ck = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      tk[i] = bus0.tick[0];
      ck[i] = bus0.clk_out[0];
    end
    chk("dflt_tick", tk, 32'h0000_00AA);
    chk("dflt_clk",  ck, 32'h0000_0066);

    // Load D=3 mid-period: held pending until the boundary, then 4 high / 4 low
    bus0.load[0] = 1'b1;
    bus0.divider[0] = 16'd3;
    step();
    bus0.load[0] = 1'b0;
    chk("ld3_pending_set", 32'(bus0.pending[0]), 32'h1);
    tk = '0; ck = '0; pd = '0;
    for (int i = 0; i < 16; i++) begin
      step();
      tk[i] = bus0.tick[0];
      ck[i] = bus0.clk_out[0];
      pd[i] = bus0.pending[0];
    end
    chk("ld3_tick",    tk, 32'h0000_1111);
    chk("ld3_clk",     ck, 32'h0000_0F0F);
    chk("ld3_pending", pd, 32'h0000_0000);

    // Disable in the terminal cycle, switch to PULSE and load D=4 while idle
    bus0.en[0] = 1'b0;
    bus0.mode[0] = 1'b1;
    bus0.load[0] = 1'b1;
    bus0.divider[0] = 16'd4;
    step();
    bus0.load[0] = 1'b0;
    chk("dis_outputs", 32'({bus0.clk_out[0], bus0.tick[0]}), 32'h0);
    chk("dis_pending_set", 32'(bus0.pending[0]), 32'h1);
    step();
    chk("dis_pending_clr", 32'(bus0.pending[0]), 32'h0);
    bus0.en[0] = 1'b1;
    tk = '0; ck = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      tk[i] = bus0.tick[0];
      ck[i] = bus0.clk_out[0];
    end
    chk("pulse4_tick", tk, 32'h0000_0210);
    chk("pulse4_clk",  ck, 32'h0000_0210);

    // PULSE with D=0: after the boundary, tick and clk_out stay high
    bus0.load[0] = 1'b1;
    bus0.divider[0] = 16'd0;
    step();
    bus0.load[0] = 1'b0;
    tk = '0; ck = '0;
    tk[0] = bus0.tick[0];
    ck[0] = bus0.clk_out[0];
    for (int i = 1; i < 8; i++) begin
      step();
      tk[i] = bus0.tick[0];
      ck[i] = bus0.clk_out[0];
    end
    chk("pulse0_tick", tk, 32'h0000_00F0);
    chk("pulse0_clk",  ck, 32'h0000_00F0);

    // Two channels, D=2 and D=5, then a one-cycle sync
    bus0.en = 2'b00;
    bus0.mode = 2'b00;
    bus0.load = 2'b11;
    bus0.divider[0] = 16'd2;
    bus0.divider[1] = 16'd5;
    step();
    bus0.load = 2'b00;
    step();
    bus0.en = 2'b11;
    repeat (4) step();
    bus0.sync = 1'b1;
    step();
    bus0.sync = 1'b0;
    chk("sync_clk_out", 32'(bus0.clk_out), 32'h0);
    chk("sync_tick",    32'(bus0.tick),    32'h0);
    tk = '0; tk1 = '0; ck = '0;
    for (int i = 0; i < 6; i++) begin
      step();
      tk[i]  = bus0.tick[0];
      tk1[i] = bus0.tick[1];
      ck[i]  = bus0.clk_out[0];
    end
    chk("sync_ch0_tick", tk,  32'h0000_0024);
    chk("sync_ch1_tick", tk1, 32'h0000_0020);
    chk("sync_ch0_clk",  ck,  32'h0000_001C);

    // Sync together with a load: the new divider is active with no pending
    bus0.sync = 1'b1;
    bus0.load = 2'b01;
    bus0.divider[0] = 16'd1;
    step();
    bus0.sync = 1'b0;
    bus0.load = 2'b00;
    chk("syncld_pending", 32'(bus0.pending), 32'h0);
    step();
    bus0.load = 2'b10;
    bus0.divider[1] = 16'd9;
    tk = '0;
    tk[0] = bus0.tick[0];
    step();
    bus0.load = 2'b00;
    tk[1] = bus0.tick[0];
    chk("syncld_tick", tk, 32'h0000_0002);
    chk("pre_rst_state", 32'({bus0.clk_out, bus0.tick, bus0.pending}), 32'b01_01_10);

    // Asynchronous reset between edges clears outputs without a clock
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_state", 32'({bus0.clk_out, bus0.tick, bus0.pending}), 32'h0);
    bus0.en = 2'b00;
    #2;
    reset = 1'b0;
    step();

    // Load D=7 while disabled, then enable: first tick 8 cycles later
    bus0.load[0] = 1'b1;
    bus0.divider[0] = 16'd7;
    step();
    bus0.load[0] = 1'b0;
    chk("ld7_pending_set", 32'(bus0.pending[0]), 32'h1);
    step();
    chk("ld7_pending_clr", 32'(bus0.pending[0]), 32'h0);
    bus0.en[0] = 1'b1;
    tk = '0;
    for (int i = 0; i < 8; i++) begin
      step();
      tk[i] = bus0.tick[0];
    end
    chk("ld7_first_tick", tk, 32'h0000_0080);

    // 4-bit instance at the maximum divider 15: tick every 16, clean wrap
    bus1.load[0] = 1'b1;
    bus1.divider[0] = 4'd15;
    step();
    bus1.load[0] = 1'b0;
    chk("w4_pending_set", 32'(bus1.pending[0]), 32'h1);
    step();
    bus1.en[0] = 1'b1;
    tk = '0;
    for (int i = 0; i < 32; i++) begin
      step();
      tk[i] = bus1.tick[0];
    end
    chk("w4_max_tick", tk, 32'h8000_8000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
